hex_write_arbiter: RTL

- Round-robin arbiter that shares a bank of NDISP seven-segment digit drivers among NREQ requesters (game logic, score counter, debug source).
- Each requester asks to write a 4-bit digit value into one display slot. The arbiter serialises the writes and drives the per-display load strobe and the shared value bus.
- Each downstream digit driver registers its load strobe one cycle before it samples the value. The value bus is therefore held stable for a second cycle after the strobe.

---
 rtl/hex_write_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/hex_write_arbiter.sv
// hex_write_arbiter: round-robin writer of 4-bit digits into NDISP display slots, one write per 3 cycles.
// Optional HEX_WRITE_RANGE_CHECK_EN drops writes whose value exceeds 9.
module hex_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int NDISP = 6
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_disp,
  input  logic [4*NREQ-1:0] req_val,
  output logic [NREQ-1:0]   ack,
  output logic [NDISP-1:0]  disp_load,
  output logic [3:0]        disp_val,
  output logic              busy,
  output logic              err
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] ptr, gnt;
  logic any, valid, drop, upd;
  logic [2:0] sel_disp;
  logic [3:0] sel_val;
  int idx;
  // descending scan so the requester closest to ptr wins
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt = PW'(idx);
        any = 1'b1;
      end
    end
  end
  assign sel_disp = req_disp[3*gnt +: 3];
  assign sel_val  = req_val[4*gnt +: 4];
  assign valid    = int'(sel_disp) < NDISP;
`ifdef HEX_WRITE_RANGE_CHECK_EN
  assign drop = sel_val > 4'd9;
`else
  assign drop = 1'b0;
`endif
  assign upd = valid && !drop;
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      ack       <= '0;
      disp_load <= '0;
      disp_val  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ack       <= '0;
      disp_load <= '0;
      err       <= 1'b0;
      if (state == IDLE && any) begin
        state     <= LOAD;
        busy      <= 1'b1;
        ack       <= NREQ'(1) << gnt;
        disp_load <= upd ? NDISP'(1) << sel_disp : '0;
        disp_val  <= upd ? sel_val : disp_val;
        err       <= !upd;
        ptr       <= gnt == PW'(NREQ - 1) ? '0 : gnt + 1'b1;
      end else if (state == LOAD) begin
        state <= HOLD;
      end else if (state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule
